// File: rtl/lorenz_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : lorenz_pkg
//  Purpose : Shared constants and types for the Lorenz solver run controller.
//            WIDTH/FRAC describe the 7.20 signed fixed-point state format.
//  Rev     : 1.0  initial release
// ============================================================================
package lorenz_pkg;

    localparam int WIDTH = 27;
    localparam int FRAC  = 20;

    typedef logic signed [WIDTH-1:0] fix27_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lorenz_sample_buf.sv
`default_nettype none
// ============================================================================
//  Module  : lorenz_sample_buf
//  Purpose : One-entry valid/ready holding register for x/y/z samples.
//            Data only changes on capture, so it is stable while valid&&!ready.
//            Capture in the same cycle as an accept keeps valid high (no bubble).
//  Ports   : clk, reset (async, active-low), flush (drop held sample),
//            capture (load d_x/y/z), ready in, valid out, q_x/y/z out.
//  Rev     : 1.0  initial release
// ============================================================================
module lorenz_sample_buf #(
    parameter int WIDTH = 27
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    capture,
    input  logic signed [WIDTH-1:0] d_x,
    input  logic signed [WIDTH-1:0] d_y,
    input  logic signed [WIDTH-1:0] d_z,
    input  logic                    ready,
    output logic                    valid,
    output logic signed [WIDTH-1:0] q_x,
    output logic signed [WIDTH-1:0] q_y,
    output logic signed [WIDTH-1:0] q_z
);

    logic                    r_valid;
    logic signed [WIDTH-1:0] r_x;
    logic signed [WIDTH-1:0] r_y;
    logic signed [WIDTH-1:0] r_z;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
        end else begin
            // flush beats capture so an abort never leaves a stale sample
            if (flush) begin
                r_valid <= 1'b0;
            end else if (capture) begin
                r_valid <= 1'b1;
            end else if (ready) begin
                r_valid <= 1'b0;
            end
            if (capture && !flush) begin
                r_x <= d_x;
                r_y <= d_y;
                r_z <= d_z;
            end
        end
    end

    assign valid = r_valid;
    assign q_x   = r_x;
    assign q_y   = r_y;
    assign q_z   = r_z;

endmodule
`default_nettype wire

// File: rtl/lorenz_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : lorenz_run_ctrl
//  Purpose : Run controller for the 7.20 fixed-point Lorenz ODE solver.
//            Loads initial conditions, enables one Euler step per cycle,
//            stops after num_steps (0 = free-run), and emits every decim-th
//            state plus the final state on a valid/ready sample port.
//            Backpressure stalls the solver so no sample is dropped.
//  Ports   : clk, reset (async active-low), start, stop, num_steps, decim,
//            solver_reset, solver_en, x_in/y_in/z_in, sample_x/y/z,
//            sample_valid, sample_ready, busy, done, step_count,
//            pause (only when LORENZ_PAUSE_EN is defined).
//  Config  : LORENZ_PAUSE_EN adds the pause input that freezes RUN.
//  Rev     : 1.0  initial release
// ============================================================================
module lorenz_run_ctrl
    import lorenz_pkg::*;
#(
    parameter int WIDTH = lorenz_pkg::WIDTH,
    parameter int CNT_W = 32,
    parameter int DEC_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
`ifdef LORENZ_PAUSE_EN
    input  logic                    pause,
`endif
    input  logic [CNT_W-1:0]        num_steps,
    input  logic [DEC_W-1:0]        decim,
    output logic                    solver_reset,
    output logic                    solver_en,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [WIDTH-1:0] z_in,
    output logic signed [WIDTH-1:0] sample_x,
    output logic signed [WIDTH-1:0] sample_y,
    output logic signed [WIDTH-1:0] sample_z,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        step_count
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [DEC_W-1:0] c_dec_one = DEC_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_num_steps;
    logic [CNT_W-1:0] r_step_count;
    logic [DEC_W-1:0] r_decim;
    logic [DEC_W-1:0] r_dcnt;
    logic             r_final_cap;
    logic             r_done;

    logic w_pause;
    logic w_buf_free;
    logic w_step_last;
    logic w_capture;
    logic w_flush;
    logic w_load_cfg;
    logic w_clear;
    logic w_adv;
    logic w_set_final;
    logic w_done_nxt;

`ifdef LORENZ_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    // The buffer can take a new sample if empty or emptying this cycle.
    assign w_buf_free  = !sample_valid || sample_ready;
    assign w_step_last = (r_num_steps != '0) &&
                         (r_step_count == r_num_steps - c_cnt_one);

    always_comb begin
        w_state_nxt = r_state;
        solver_en   = 1'b0;
        w_capture   = 1'b0;
        w_flush     = 1'b0;
        w_load_cfg  = 1'b0;
        w_clear     = 1'b0;
        w_adv       = 1'b0;
        w_set_final = 1'b0;
        w_done_nxt  = 1'b0;

        if (stop) begin
            // stop wins over start and pause, and suppresses done
            w_state_nxt = IDLE;
            w_flush     = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_state_nxt = LOAD;
                        w_load_cfg  = 1'b1;
                    end
                end
                LOAD: begin
                    w_clear     = 1'b1;
                    w_state_nxt = RUN;
                end
                RUN: begin
                    if (!w_pause) begin
                        if (r_dcnt == '0) begin
                            // capture the pre-step state; stall if buffer full
                            if (w_buf_free) begin
                                w_capture = 1'b1;
                                w_adv     = 1'b1;
                            end
                        end else begin
                            w_adv = 1'b1;
                        end
                    end
                    if (w_adv) begin
                        solver_en = 1'b1;
                        if (w_step_last) begin
                            w_state_nxt = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!r_final_cap) begin
                        if (w_buf_free) begin
                            w_capture   = 1'b1;
                            w_set_final = 1'b1;
                        end
                    end else if (sample_valid && sample_ready) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_num_steps  <= '0;
            r_decim      <= c_dec_one;
            r_step_count <= '0;
            r_dcnt       <= '0;
            r_final_cap  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            if (w_load_cfg) begin
                r_num_steps <= num_steps;
                r_decim     <= (decim == '0) ? c_dec_one : decim;
            end
            if (w_clear) begin
                r_step_count <= '0;
                r_dcnt       <= '0;
                r_final_cap  <= 1'b0;
            end else if (w_adv) begin
                // saturate in free-run; the solver itself keeps stepping
                if (r_step_count != '1) begin
                    r_step_count <= r_step_count + c_cnt_one;
                end
                r_dcnt <= (r_dcnt == r_decim - c_dec_one) ? '0 : r_dcnt + c_dec_one;
            end
            if (w_set_final) begin
                r_final_cap <= 1'b1;
            end
        end
    end

    lorenz_sample_buf #(
        .WIDTH (WIDTH)
    ) u_sample_buf (
        .clk     (clk),
        .reset   (reset),
        .flush   (w_flush),
        .capture (w_capture),
        .d_x     (x_in),
        .d_y     (y_in),
        .d_z     (z_in),
        .ready   (sample_ready),
        .valid   (sample_valid),
        .q_x     (sample_x),
        .q_y     (sample_y),
        .q_z     (sample_z)
    );

    assign solver_reset = (r_state == IDLE) || (r_state == LOAD);
    assign busy         = (r_state != IDLE);
    assign done         = r_done;
    assign step_count   = r_step_count;

endmodule
`default_nettype wire

// File: tb/tb_lorenz_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_lorenz_run_ctrl
//  Purpose : Self-checking bench for lorenz_run_ctrl with a toy solver model
//            (x+=1, y+=5, z-=3 per enabled step) and a sample scoreboard.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_lorenz_run_ctrl;
    import lorenz_pkg::*;

    localparam int CNT_W = 32;
    localparam int DEC_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             stop;
    logic             pause;
    logic [CNT_W-1:0] num_steps;
    logic [DEC_W-1:0] decim;
    logic             solver_reset;
    logic             solver_en;
    fix27_t           sx, sy, sz;
    fix27_t           sample_x, sample_y, sample_z;
    logic             sample_valid;
    logic             sample_ready;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] step_count;

    lorenz_run_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .DEC_W (DEC_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
`ifdef LORENZ_PAUSE_EN
        .pause        (pause),
`endif
        .num_steps    (num_steps),
        .decim        (decim),
        .solver_reset (solver_reset),
        .solver_en    (solver_en),
        .x_in         (sx),
        .y_in         (sy),
        .z_in         (sz),
        .sample_x     (sample_x),
        .sample_y     (sample_y),
        .sample_z     (sample_z),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .done         (done),
        .step_count   (step_count)
    );

    always #5 clk = ~clk;

    // toy solver: state after s steps is (100+s, 200+5s, -50-3s)
    always @(posedge clk) begin
        if (solver_reset) begin
            sx <= 27'sd100;
            sy <= 27'sd200;
            sz <= -27'sd50;
        end else if (solver_en) begin
            sx <= sx + 27'sd1;
            sy <= sy + 27'sd5;
            sz <= sz - 27'sd3;
        end
    end

    typedef struct {
        fix27_t x;
        fix27_t y;
        fix27_t z;
    } samp_t;

    samp_t sb_q[$];
    samp_t mon_e;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int en_cnt = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_acc_cyc = 0;

    task automatic push_exp(input int s);
        samp_t e;
        e.x = fix27_t'(100 + s);
        e.y = fix27_t'(200 + 5 * s);
        e.z = fix27_t'(-50 - 3 * s);
        sb_q.push_back(e);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (solver_en) en_cnt++;
        if (reset && sample_valid && sample_ready) begin
            acc_cnt++;
            last_acc_cyc = cyc;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sample_unexpected: got (%0d,%0d,%0d), required no sample",
                         sample_x, sample_y, sample_z);
            end else begin
                mon_e = sb_q.pop_front();
                if (sample_x !== mon_e.x || sample_y !== mon_e.y || sample_z !== mon_e.z) begin
                    errors++;
                    $display("FAIL sample_data: got (%0d,%0d,%0d), required (%0d,%0d,%0d)",
                             sample_x, sample_y, sample_z, mon_e.x, mon_e.y, mon_e.z);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int n, input int d, input bit push);
        int dd;
        dd = (d == 0) ? 1 : d;
        en_cnt   = 0;
        acc_cnt  = 0;
        done_cnt = 0;
        if (push && n > 0) begin
            for (int s = 0; s < n; s += dd) push_exp(s);
            push_exp(n);
        end
        num_steps = CNT_W'(n);
        decim     = DEC_W'(d);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s_timeout: got no done within %0d cycles, required done", name, budget);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        pause = 1'b0;
        sample_ready = 1'b1;
        num_steps = '0;
        decim = '0;
        #12;
        checks++;
        if ({solver_reset, solver_en, sample_valid, busy, done} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 10000",
                     {solver_reset, solver_en, sample_valid, busy, done});
        end
        checks++;
        if ({sample_x, sample_y, sample_z} !== '0) begin
            errors++;
            $display("FAIL reset_sample: got (%0d,%0d,%0d), required 0", sample_x, sample_y, sample_z);
        end
        checks++;
        if (step_count !== '0) begin
            errors++;
            $display("FAIL reset_step_count: got %0d, required 0", step_count);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        sample_ready = 1'b1;
        start_run(10, 4, 1'b1);
        @(negedge clk);
        checks++;
        if (solver_en !== 1'b0 || solver_reset !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL load_cycle: got en=%b rst=%b busy=%b, required 0 1 1",
                     solver_en, solver_reset, busy);
        end
        @(negedge clk);
        checks++;
        if (solver_en !== 1'b1 || solver_reset !== 1'b0) begin
            errors++;
            $display("FAIL first_enable: got en=%b rst=%b, required 1 0", solver_en, solver_reset);
        end
        wait_done(100, "basic");
        checks++;
        if (en_cnt != 10) begin
            errors++;
            $display("FAIL basic_en_count: got %0d, required 10", en_cnt);
        end
        checks++;
        if (acc_cnt != 4 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL basic_samples: got %0d accepted %0d left, required 4 0", acc_cnt, sb_q.size());
        end
        checks++;
        if (done_cyc != last_acc_cyc + 1) begin
            errors++;
            $display("FAIL basic_done_timing: got cycle %0d, required %0d", done_cyc, last_acc_cyc + 1);
        end
        repeat (3) tick();
        checks++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: got count=%0d busy=%b, required 1 0", done_cnt, busy);
        end
        sb_q.delete();
    endtask

    task automatic test_backpressure;
        int k;
        sample_ready = 1'b0;
        start_run(8, 1, 1'b1);
        k = 0;
        @(negedge clk);
        while (sample_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (sample_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_first_valid: got no valid, required valid");
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (solver_en !== 1'b0 || step_count !== 32'd1) begin
                errors++;
                $display("FAIL bp_stall: got en=%b step_count=%0d, required 0 1", solver_en, step_count);
            end
            if (i < 4) @(negedge clk);
        end
        @(posedge clk);
        #1;
        sample_ready = 1'b1;
        wait_done(100, "bp");
        checks++;
        if (en_cnt != 8 || acc_cnt != 9 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL bp_counts: got en=%0d acc=%0d left=%0d, required 8 9 0",
                     en_cnt, acc_cnt, sb_q.size());
        end
        sb_q.delete();
        tick();
    endtask

    task automatic test_freerun;
        int k;
        sample_ready = 1'b1;
        for (int s = 0; s < 1600; s += 2) push_exp(s);
        start_run(0, 2, 1'b0);
        k = 0;
        while (step_count <= 32'd1000 && k < 1500) begin
            tick();
            k++;
        end
        checks++;
        if (step_count <= 32'd1000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL free_progress: got step_count=%0d busy=%b, required >1000 1", step_count, busy);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || sample_valid !== 1'b0 || solver_en !== 1'b0) begin
            errors++;
            $display("FAIL free_stop: got busy=%b valid=%b en=%b, required 0 0 0",
                     busy, sample_valid, solver_en);
        end
        repeat (5) tick();
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL free_no_done: got %0d done pulses, required 0", done_cnt);
        end
        sb_q.delete();
    endtask

    task automatic test_async_reset;
        int k;
        sample_ready = 1'b1;
        start_run(100, 3, 1'b1);
        k = 0;
        @(negedge clk);
        while (step_count !== 32'd37 && k < 100) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (step_count !== 32'd37) begin
            errors++;
            $display("FAIL ar_reach37: got %0d, required 37", step_count);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({solver_reset, solver_en, sample_valid, busy, done} !== 5'b10000 ||
            step_count !== '0 || {sample_x, sample_y, sample_z} !== '0) begin
            errors++;
            $display("FAIL ar_values: got ctrl=%b step_count=%0d x=%0d, required 10000 0 0",
                     {solver_reset, solver_en, sample_valid, busy, done}, step_count, sample_x);
        end
        sb_q.delete();
        tick();
        tick();
        reset = 1'b1;
        tick();
        start_run(6, 3, 1'b1);
        wait_done(100, "ar_rerun");
        checks++;
        if (en_cnt != 6 || acc_cnt != 3 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL ar_rerun_counts: got en=%0d acc=%0d left=%0d, required 6 3 0",
                     en_cnt, acc_cnt, sb_q.size());
        end
        sb_q.delete();
        tick();
    endtask

    task automatic test_start_stop;
        logic [CNT_W-1:0] sc;
        sample_ready = 1'b1;
        en_cnt = 0;
        num_steps = 32'd5;
        decim = 16'd1;
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || solver_en !== 1'b0 || en_cnt != 0) begin
            errors++;
            $display("FAIL ss_idle: got busy=%b en=%b en_cnt=%0d, required 0 0 0", busy, solver_en, en_cnt);
        end
        start_run(12, 5, 1'b1);
        repeat (4) tick();
        sc = step_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (step_count !== sc + 32'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ss_start_in_run: got %0d busy=%b, required %0d 1", step_count, busy, sc + 32'd1);
        end
        wait_done(100, "ss");
        checks++;
        if (en_cnt != 12 || acc_cnt != 4 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL ss_counts: got en=%0d acc=%0d left=%0d, required 12 4 0",
                     en_cnt, acc_cnt, sb_q.size());
        end
        sb_q.delete();
        tick();
    endtask

`ifdef LORENZ_PAUSE_EN
    task automatic test_pause;
        int s0, c0, s1, c1, k;
        sample_ready = 1'b1;
        start_run(20, 5, 1'b1);
        s0 = cyc;
        wait_done(200, "pause_ref");
        c0 = done_cyc - s0;
        sb_q.delete();
        tick();
        start_run(20, 5, 1'b1);
        s1 = cyc;
        k = 0;
        while (step_count !== 32'd7 && k < 50) begin
            tick();
            k++;
        end
        pause = 1'b1;
        repeat (3) tick();
        pause = 1'b0;
        checks++;
        if (step_count !== 32'd7) begin
            errors++;
            $display("FAIL pause_frozen: got %0d, required 7", step_count);
        end
        wait_done(200, "pause");
        c1 = done_cyc - s1;
        checks++;
        if (c1 != c0 + 3 || acc_cnt != 5 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL pause_run: got len=%0d acc=%0d left=%0d, required %0d 5 0",
                     c1, acc_cnt, sb_q.size(), c0 + 3);
        end
        sb_q.delete();
        tick();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_freerun();
        test_async_reset();
        test_start_stop();
`ifdef LORENZ_PAUSE_EN
        test_pause();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
